mem_trace_replayer: RTL and testbench

//  Consumes 64-bit memory-trace records from the trace-source valid/ready stream and

---
 rtl/mem_trace_pkg.sv | 26 ++
 rtl/mem_trace_fifo.sv | 46 ++++
 rtl/mem_trace_replayer.sv | 140 ++++++++++++++
 tb/tb_mem_trace_replayer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_trace_pkg.sv
// Shared types and constants for the memory-trace replayer: record layout,
// FSM states, and the byte-mask helper used to build request masks.
package mem_trace_pkg;

  typedef struct packed {
    logic        store;
    logic [2:0]  size_log2;
    logic [11:0] delay;
    logic [47:0] addr;
  } trace_rec_t;

  localparam logic [63:0] END_MARKER = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [2:0]  SIZE_MAX   = 3'd3;
  localparam logic [31:0] STORE_XOR  = 32'hA5A5_A5A5;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DONE} state_e;

  // Bytes touched by a 2^size access at byte offset off, clipped to the 8-byte word.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/mem_trace_fifo.sv
// Synchronous power-of-two FIFO buffering trace records ahead of the replay FSM.
// Caller guarantees no push when full and no pop when empty.
module mem_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mem_trace_replayer.sv
// Replays 64-bit trace records as timed load/store requests with an outstanding cap.
// Optional counters enabled by defining MEM_TRACE_REPLAYER_STATS_EN.
module mem_trace_replayer
  import mem_trace_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int ADDR_W       = 48,
  parameter int DATA_W       = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trace_valid,
  output logic                trace_ready,
  input  logic [63:0]         trace_bits,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_store,
  output logic [2:0]          req_size,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_data,
  output logic [DATA_W/8-1:0] req_mask,
  input  logic                resp_valid,
  output logic [7:0]          inflight,
  output logic                done,
  output logic                err
`ifdef MEM_TRACE_REPLAYER_STATS_EN
  ,
  output logic [31:0]         stat_reqs,
  output logic [31:0]         stat_stall,
  output logic [31:0]         stat_cycles
`endif
);
  logic        push, pop, full, empty, hs, rsp;
  logic [63:0] fifo_rdata;
  logic [3:0]  align;
  trace_rec_t  rec, cur_q, cur_d;
  state_e      state_q, state_d;
  logic [7:0]  inflight_q, inflight_d;
  logic        err_q, err_d;

  mem_trace_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .wdata(trace_bits), .rdata(fifo_rdata), .full(full), .empty(empty)
  );

  assign rec         = trace_rec_t'(fifo_rdata);
  assign trace_ready = reset && !full && (state_q != DONE);
  assign push        = trace_valid && trace_ready;
  assign pop         = (state_q == IDLE) && !empty;
  assign hs          = req_valid && req_ready;
  assign rsp         = resp_valid && (inflight_q != 8'd0);

  // cur_q.delay doubles as the countdown once the record is latched.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    err_d      = err_q;
    align      = 4'd0;
    inflight_d = inflight_q + 8'(hs) - 8'(rsp);
    if (resp_valid && inflight_q == 8'd0) err_d = 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        if (fifo_rdata == END_MARKER) begin
          state_d = DONE;
        end else begin
          cur_d   = rec;
          state_d = WAIT;
          if (rec.size_log2 > SIZE_MAX) begin
            cur_d.size_log2 = SIZE_MAX;
            err_d           = 1'b1;
          end
          align = (4'd1 << cur_d.size_log2) - 4'd1;
          if (({1'b0, rec.addr[2:0]} & align) != 4'd0) err_d = 1'b1;
        end
      end
      WAIT: begin
        if (cur_q.delay != 12'd0) cur_d.delay = cur_q.delay - 12'd1;
        else if (inflight_q < 8'(MAX_INFLIGHT)) state_d = ISSUE;
      end
      ISSUE: if (req_ready) state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign req_valid = (state_q == ISSUE);
  assign req_store = cur_q.store;
  assign req_size  = cur_q.size_log2;
  assign req_addr  = cur_q.addr[ADDR_W-1:0];
  assign req_data  = cur_q.store ? DATA_W'({2{cur_q.addr[31:0] ^ STORE_XOR}}) : '0;
  assign req_mask  = (DATA_W/8)'(byte_mask(cur_q.size_log2[1:0], cur_q.addr[2:0]));
  assign inflight  = inflight_q;
  assign done      = (state_q == DONE) && (inflight_q == 8'd0);
  assign err       = err_q;

`ifdef MEM_TRACE_REPLAYER_STATS_EN
  logic [31:0] reqs_q, reqs_d, stall_q, stall_d, cyc_q, cyc_d;
  logic        stall;

  assign stall = (state_q == ISSUE && !req_ready) ||
                 (state_q == WAIT && cur_q.delay == 12'd0 && inflight_q >= 8'(MAX_INFLIGHT));

  always_comb begin
    reqs_d  = (hs && reqs_q != '1) ? reqs_q + 32'd1 : reqs_q;
    stall_d = (stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    cyc_d   = (!done && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reqs_q  <= '0;
      stall_q <= '0;
      cyc_q   <= '0;
    end else begin
      reqs_q  <= reqs_d;
      stall_q <= stall_d;
      cyc_q   <= cyc_d;
    end
  end

  assign stat_reqs   = reqs_q;
  assign stat_stall  = stall_q;
  assign stat_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mem_trace_replayer.sv
// Directed bench for mem_trace_replayer: latency, data/mask, inflight cap,
// end marker, error flags, mid-operation reset and simultaneous handshake/response.
module tb_mem_trace_replayer;
  localparam int MAXI = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        trace_valid = 1'b0, trace_ready;
  logic [63:0] trace_bits = '0;
  logic        req_valid, req_ready = 1'b0, req_store;
  logic [2:0]  req_size;
  logic [47:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_mask;
  logic        resp_valid = 1'b0;
  logic [7:0]  inflight;
  logic        done, err;
`ifdef MEM_TRACE_REPLAYER_STATS_EN
  logic [31:0] stat_reqs, stat_stall, stat_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_trace_replayer #(.FIFO_DEPTH(4), .MAX_INFLIGHT(MAXI), .ADDR_W(48), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_bits(trace_bits),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .resp_valid(resp_valid), .inflight(inflight), .done(done), .err(err)
`ifdef MEM_TRACE_REPLAYER_STATS_EN
    , .stat_reqs(stat_reqs), .stat_stall(stat_stall), .stat_cycles(stat_cycles)
`endif
  );

  function automatic logic [63:0] mk(input logic st, input logic [2:0] sz,
                                     input logic [11:0] dl, input logic [47:0] ad);
    return {st, sz, dl, ad};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; trace_valid = 1'b0; trace_bits = '0; req_ready = 1'b0; resp_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic send(input logic [63:0] r);
    int n;
    n = 0;
    trace_bits = r; trace_valid = 1'b1;
    while (!trace_ready && n < 50) begin step(); n++; end
    n_checks++; if (trace_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready got %b exp 1", trace_ready); end
    step();
    trace_valid = 1'b0;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (req_valid !== 1'b1 && cyc < 100) begin step(); cyc++; end
  endtask

  task automatic test_reset();
    reset = 1'b0; trace_valid = 1'b1;
    step();
    n_checks++; if (trace_ready !== 1'b0) begin n_fail++; $display("FAIL rst_trace_ready got %b exp 0", trace_ready); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
    n_checks++; if (inflight !== 8'd0) begin n_fail++; $display("FAIL rst_inflight got %0d exp 0", inflight); end
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL rst_done_err got %b exp 00", {done, err}); end
    trace_valid = 1'b0;
    reset = 1'b1;
    step();
    n_checks++; if (trace_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b exp 1", trace_ready); end
  endtask

  task automatic test_load_latency();
    int c;
    do_reset(); req_ready = 1'b1;
    send(mk(1'b0, 3'd2, 12'd0, 48'h1004));
    wait_req(c);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL load_latency got %0d exp 2", c); end
    n_checks++; if (req_mask !== 8'hF0) begin n_fail++; $display("FAIL load_mask got %h exp f0", req_mask); end
    n_checks++; if ({req_store, req_size} !== 4'b0010) begin n_fail++; $display("FAIL load_store_size got %b exp 0010", {req_store, req_size}); end
    n_checks++; if (req_addr !== 48'h1004) begin n_fail++; $display("FAIL load_addr got %h exp 1004", req_addr); end
    n_checks++; if (req_data !== 64'h0) begin n_fail++; $display("FAIL load_data got %h exp 0", req_data); end
    step();
    n_checks++; if (inflight !== 8'd1) begin n_fail++; $display("FAIL load_inflight got %0d exp 1", inflight); end
  endtask

  task automatic test_store_delay();
    int c;
    do_reset(); req_ready = 1'b1;
    send(mk(1'b1, 3'd3, 12'd5, 48'h40));
    wait_req(c);
    n_checks++; if (c != 7) begin n_fail++; $display("FAIL store_latency got %0d exp 7", c); end
    n_checks++; if (req_data !== 64'hA5A5_A5E5_A5A5_A5E5) begin n_fail++; $display("FAIL store_data got %h exp a5a5a5e5a5a5a5e5", req_data); end
    n_checks++; if (req_mask !== 8'hFF) begin n_fail++; $display("FAIL store_mask got %h exp ff", req_mask); end
    n_checks++; if ({req_store, err} !== 2'b10) begin n_fail++; $display("FAIL store_flag_err got %b exp 10", {req_store, err}); end
  endtask

  task automatic test_inflight_cap();
    int c;
    do_reset(); req_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(mk(1'b0, 3'd3, 12'd0, 48'(i * 8)));
    repeat (20) step();
    n_checks++; if (inflight !== 8'd4) begin n_fail++; $display("FAIL cap_inflight got %0d exp 4", inflight); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL cap_stall got %b exp 0", req_valid); end
    resp_valid = 1'b1; step(); resp_valid = 1'b0;
    n_checks++; if (inflight !== 8'd3) begin n_fail++; $display("FAIL cap_resp got %0d exp 3", inflight); end
    wait_req(c);
    n_checks++; if (c != 1 || req_addr !== 48'd32) begin n_fail++; $display("FAIL cap_resume got %0d/%h exp 1/20", c, req_addr); end
    step();
    n_checks++; if (inflight !== 8'd4) begin n_fail++; $display("FAIL cap_refill got %0d exp 4", inflight); end
  endtask

  task automatic test_end_marker();
    do_reset(); req_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(1'b0, 3'd3, 12'd0, 48'h100 + 48'(i * 8)));
    send(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (15) step();
    n_checks++; if (inflight !== 8'd3) begin n_fail++; $display("FAIL end_inflight got %0d exp 3", inflight); end
    n_checks++; if ({done, trace_ready, req_valid, err} !== 4'b0000) begin n_fail++; $display("FAIL end_flags got %b exp 0000", {done, trace_ready, req_valid, err}); end
    resp_valid = 1'b1; step(); step();
    n_checks++; if ({inflight, done} !== {8'd1, 1'b0}) begin n_fail++; $display("FAIL end_pre_done got %0d/%b exp 1/0", inflight, done); end
    step(); resp_valid = 1'b0;
    n_checks++; if ({inflight, done} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL end_done got %0d/%b exp 0/1", inflight, done); end
    step();
    n_checks++; if ({done, trace_ready} !== 2'b10) begin n_fail++; $display("FAIL end_terminal got %b exp 10", {done, trace_ready}); end
  endtask

  task automatic test_err();
    int c;
    do_reset();
    resp_valid = 1'b1; step(); resp_valid = 1'b0;
    n_checks++; if ({err, inflight} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL err_resp got %b/%0d exp 1/0", err, inflight); end
    repeat (3) step();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
    do_reset();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
    req_ready = 1'b1;
    send(mk(1'b0, 3'd5, 12'd0, 48'h0));
    wait_req(c);
    n_checks++; if ({req_size, req_mask, err} !== {3'd3, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL err_size got %0d/%h/%b exp 3/ff/1", req_size, req_mask, err); end
    do_reset(); req_ready = 1'b1;
    send(mk(1'b0, 3'd2, 12'd0, 48'h1002));
    wait_req(c);
    n_checks++; if ({req_valid, req_mask, err} !== {1'b1, 8'h3C, 1'b1}) begin n_fail++; $display("FAIL err_misalign got %b/%h/%b exp 1/3c/1", req_valid, req_mask, err); end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset(); req_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(1'b0, 3'd3, 12'd0, 48'(i * 8)));
    repeat (10) step();
    req_ready = 1'b0;
    send(mk(1'b0, 3'd3, 12'd0, 48'd24));
    wait_req(c);
    n_checks++; if ({req_valid, inflight} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL mid_pre got %b/%0d exp 1/3", req_valid, inflight); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({req_valid, inflight, trace_ready} !== {1'b0, 8'd0, 1'b0}) begin n_fail++; $display("FAIL mid_async got %b/%0d/%b exp 0/0/0", req_valid, inflight, trace_ready); end
    step(); step();
    reset = 1'b1;
    step();
    req_ready = 1'b1;
    send(mk(1'b0, 3'd3, 12'd0, 48'h2000));
    wait_req(c);
    n_checks++; if (c != 2 || req_addr !== 48'h2000 || err !== 1'b0) begin n_fail++; $display("FAIL mid_replay got %0d/%h/%b exp 2/2000/0", c, req_addr, err); end
    step();
    resp_valid = 1'b1; step(); step(); resp_valid = 1'b0;
    n_checks++; if ({inflight, err} !== {8'd0, 1'b1}) begin n_fail++; $display("FAIL mid_stale got %0d/%b exp 0/1", inflight, err); end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset(); req_ready = 1'b1;
    send(mk(1'b0, 3'd3, 12'd0, 48'h0));
    wait_req(c); step();
    req_ready = 1'b0;
    send(mk(1'b0, 3'd3, 12'd0, 48'h8));
    wait_req(c);
    n_checks++; if ({req_valid, inflight} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL b2b_pre got %b/%0d exp 1/1", req_valid, inflight); end
    req_ready = 1'b1; resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    n_checks++; if ({req_valid, inflight} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL b2b_inflight got %b/%0d exp 0/1", req_valid, inflight); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_latency();
    test_store_delay();
    test_inflight_cap();
    test_end_marker();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
